// File: rtl/queue_param.sv
// Parametrised synchronous FIFO between the cache front end and the memory-side sequencer.
// Optional first-word-fall-through output when QUEUE_FWFT_EN is defined; registered read data otherwise.
module queue_param #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              write_en,
   input  logic              read_en,
   output logic [DATA_W-1:0] out_data,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  cnt;
   logic              rd_acc, wr_acc;

   // Flags decode only from the count register, never from this cycle's requests.
   assign empty       = (cnt == '0);
   assign full        = (cnt == CNT_W'(DEPTH));
   assign almost_full = (cnt >= CNT_W'(AF_LEVEL));
   assign count       = cnt;

   // A pop in the same cycle frees the slot, so a full queue still takes the write.
   assign rd_acc = read_en && !empty;
   assign wr_acc = write_en && (!full || rd_acc);

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
         overflow  <= write_en && !wr_acc;
         underflow <= read_en && !rd_acc;
      end
   end

`ifdef QUEUE_FWFT_EN
   assign out_data = empty ? '0 : mem[rd_ptr];
`else
   logic [DATA_W-1:0] out_q;

   // Holds the last popped word until the next accepted read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        out_q <= '0;
      else if (rd_acc) out_q <= mem[rd_ptr];
   end

   assign out_data = out_q;
`endif

endmodule

// File: tb/tb_queue_param.sv
// Randomised self-checking bench for queue_param against a queue-based reference model.
module tb_queue_param;
   localparam int DATA_W = 8, DEPTH = 4, AF_LEVEL = 3, CNT_W = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] in_data;
   logic              write_en, read_en;
   logic [DATA_W-1:0] out_data;
   logic              empty, full, almost_full, overflow, underflow;
   logic [CNT_W-1:0]  count;

   queue_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .write_en(write_en), .read_en(read_en),
      .out_data(out_data), .empty(empty), .full(full), .almost_full(almost_full),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;
   bit chk_en = 1'b0;

   // Reference model: contents as a plain queue, last popped word, pulse expectations.
   logic [DATA_W-1:0] q[$];
   logic [DATA_W-1:0] m_out;
   bit m_ovf, m_udf;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_out = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic model_update(input bit we, input bit re, input logic [DATA_W-1:0] d);
      bit rd_ok, wr_ok;
      rd_ok = re && (q.size() > 0);
      wr_ok = we && ((q.size() < DEPTH) || rd_ok);
      m_ovf = we && !wr_ok;
      m_udf = re && !rd_ok;
      if (rd_ok) m_out = q.pop_front();
      if (wr_ok) q.push_back(d);
   endtask

   function automatic int exp_out();
`ifdef QUEUE_FWFT_EN
      return (q.size() > 0) ? int'(q[0]) : 0;
`else
      return int'(m_out);
`endif
   endfunction

   always @(negedge clk) begin
      #2;
      if (chk_en) begin
         chk("count",       int'(count),       q.size());
         chk("empty",       int'(empty),       int'(q.size() == 0));
         chk("full",        int'(full),        int'(q.size() == DEPTH));
         chk("almost_full", int'(almost_full), int'(q.size() >= AF_LEVEL));
         chk("out_data",    int'(out_data),    exp_out());
         chk("overflow",    int'(overflow),    int'(m_ovf));
         chk("underflow",   int'(underflow),   int'(m_udf));
      end
   end

   task automatic step(input bit r, input bit we, input bit re, input logic [DATA_W-1:0] d);
      @(negedge clk);
      rst = r; write_en = we; read_en = re; in_data = d;
      if (!r) model_clear();
      @(posedge clk);
      if (r) model_update(we, re, d);
      else   model_clear();
      #1;
   endtask

   initial begin
      rst = 1'b0; write_en = 1'b0; read_en = 1'b0; in_data = '0;
      model_clear();
      chk_en = 1'b1;

      // Reset held with write_en asserted: nothing may be stored.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h99);
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_out",   int'(out_data), 0);

      // Fill and overflow.
      step(1'b1, 1'b1, 1'b0, 8'h07);
      step(1'b1, 1'b1, 1'b0, 8'h01);
      step(1'b1, 1'b1, 1'b0, 8'h02);
      chk("af_after_3", int'(almost_full), 1);
      chk("full_after_3", int'(full), 0);
      step(1'b1, 1'b1, 1'b0, 8'h03);
      chk("full_after_4", int'(full), 1);
      step(1'b1, 1'b1, 1'b0, 8'h04);
      chk("ovf_pulse", int'(overflow), 1);
      chk("ovf_count", int'(count), 4);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("ovf_clear", int'(overflow), 0);

      // Drain and underflow.
`ifndef QUEUE_FWFT_EN
      step(1'b1, 1'b0, 1'b1, 8'h00); chk("drain0", int'(out_data), 8'h07);
      step(1'b1, 1'b0, 1'b1, 8'h00); chk("drain1", int'(out_data), 8'h01);
      step(1'b1, 1'b0, 1'b1, 8'h00); chk("drain2", int'(out_data), 8'h02);
      step(1'b1, 1'b0, 1'b1, 8'h00); chk("drain3", int'(out_data), 8'h03);
      chk("drain_empty", int'(empty), 1);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("udf_pulse", int'(underflow), 1);
      chk("udf_hold", int'(out_data), 8'h03);
`else
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("udf_pulse", int'(underflow), 1);
`endif

      // Full with simultaneous read and write.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
      step(1'b1, 1'b1, 1'b1, 8'h55);
`ifndef QUEUE_FWFT_EN
      chk("rw_full_out", int'(out_data), 8'h20);
`endif
      chk("rw_full_count", int'(count), 4);
      chk("rw_full_ovf", int'(overflow), 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'h00);

      // Interleaved write/read across the pointer wrap.
      step(1'b1, 1'b1, 1'b0, 8'h10);
      for (int i = 1; i < 10; i++) step(1'b1, 1'b1, 1'b1, 8'(8'h10 + i));
      step(1'b1, 1'b0, 1'b1, 8'h00);
`ifndef QUEUE_FWFT_EN
      chk("wrap_last", int'(out_data), 8'h19);
`endif

      // Mid-operation reset discards contents.
      step(1'b1, 1'b1, 1'b0, 8'h3c);
      step(1'b1, 1'b1, 1'b0, 8'h3d);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("midrst_count", int'(count), 0);

`ifdef QUEUE_FWFT_EN
      step(1'b1, 1'b1, 1'b0, 8'hA5);
      chk("fwft_show", int'(out_data), 8'hA5);
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("fwft_empty", int'(empty), 1);
      chk("fwft_zero", int'(out_data), 0);
`endif

      // Randomised traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         bit r, we, re;
         r  = ($urandom_range(0, 199) != 0);
         we = ($urandom_range(0, 99) < 55);
         re = ($urandom_range(0, 99) < 50);
         step(r, we, re, 8'($urandom));
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
